// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S 16-bit processor: instruction decode, control FSM
// states, ALU operation codes and the conditional-branch evaluator.
package k_and_s_pkg;

    // Five bits leave encodings 16..31 free; the FSM treats those as no-ops.
    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_HALT   = 5'd15
    } decoded_instruction_type;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EX_LOAD,
        S_EX_STORE,
        S_EX_MOVE,
        S_EX_ALU,
        S_EX_BRANCH,
        S_HALT
    } ctrl_state_type;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    function automatic logic branch_cond(
        input decoded_instruction_type instr,
        input logic                    zero_op,
        input logic                    neg_op,
        input logic                    unsigned_overflow,
        input logic                    signed_overflow
    );
        logic ovf;
        logic taken;
        ovf   = signed_overflow | unsigned_overflow;
        taken = 1'b0;
        case (instr)
            I_BRANCH: taken = 1'b1;
            I_BZERO:  taken = zero_op;
            I_BNZERO: taken = ~zero_op;
            I_BNEG:   taken = neg_op;
            I_BNNEG:  taken = ~neg_op;
            I_BOV:    taken = ovf;
            I_BNOV:   taken = ~ovf;
            default:  taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the K&S datapath. Outputs are
// decoded from the registered state and RAM wait counter; MEM_WAIT is 0..7.
module control_unit
    import k_and_s_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halted
);

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    ctrl_state_type state;
    logic [2:0]     wait_cnt;
    logic           mem_done;

    // The last cycle of a RAM access is the one where the counter has run out.
    assign mem_done = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= 3'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_done) begin
                        state    <= S_DECODE;
                        wait_cnt <= 3'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                S_DECODE: begin
                    wait_cnt <= 3'd0;
                    case (decoded_instruction)
                        I_LOAD:  state <= S_EX_LOAD;
                        I_STORE: state <= S_EX_STORE;
                        I_MOVE:  state <= S_EX_MOVE;
                        I_ADD, I_SUB, I_AND, I_OR:
                                 state <= S_EX_ALU;
                        I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
                                 state <= S_EX_BRANCH;
                        I_HALT:  state <= S_HALT;
                        default: state <= S_FETCH;
                    endcase
                end
                S_EX_LOAD: begin
                    if (mem_done) begin
                        state    <= S_FETCH;
                        wait_cnt <= 3'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                S_HALT: begin
                    state    <= S_HALT;
                    wait_cnt <= 3'd0;
                end
                default: begin
                    state    <= S_FETCH;
                    wait_cnt <= 3'd0;
                end
            endcase
        end
    end

    // Reset gates the decode so an abandoned instruction cannot strobe anything.
    always_comb begin
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = OP_OR;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halted           = 1'b0;
        if (rst) begin
            addr_sel = 1'b1;
        end else begin
            case (state)
                S_FETCH: begin
                    addr_sel  = 1'b1;
                    ir_enable = mem_done;
                    pc_enable = mem_done;
                end
                S_EX_LOAD: begin
                    write_reg_enable = mem_done;
                end
                S_EX_STORE: begin
                    ram_write_enable = 1'b1;
                end
                S_EX_MOVE: begin
                    c_sel            = 1'b1;
                    write_reg_enable = 1'b1;
                end
                S_EX_ALU: begin
                    c_sel            = 1'b1;
                    write_reg_enable = 1'b1;
                    flags_reg_enable = 1'b1;
                    case (decoded_instruction)
                        I_ADD:   operation = OP_ADD;
                        I_SUB:   operation = OP_SUB;
                        I_AND:   operation = OP_AND;
                        default: operation = OP_OR;
                    endcase
                end
                S_EX_BRANCH: begin
                    pc_enable = 1'b1;
                    branch    = branch_cond(decoded_instruction, zero_op, neg_op,
                                            unsigned_overflow, signed_overflow);
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
